// File: rtl/lc2k_multicycle_ctrl.sv
// Multi-cycle control FSM for the LC2K datapath: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions. Optional memory timeout (sticky FAULT) enabled by LC2K_MEM_TIMEOUT_EN.
module lc2k_multicycle_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             alu_eq,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             write_reg_sel,
    output logic [1:0]       write_data_sel,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] instr_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic             retire;
    logic             timeout_hit;
    logic [CNT_W-1:0] retired_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (state == S_DECODE) begin
            op_q <= opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end

`ifdef LC2K_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_waiting;

    assign mem_waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    // A ready in the limit cycle completes the access instead of faulting.
    assign timeout_hit = mem_waiting && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (mem_waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_nxt = S_DECODE;
                else if (timeout_hit) state_nxt = S_FAULT;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_NOR: state_nxt = S_WB;
                    OP_LW, OP_SW:   state_nxt = S_MEM;
                    OP_HALT:        state_nxt = S_HALTED;
                    default:        state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)        state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (timeout_hit) state_nxt = S_FAULT;
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALTED: state_nxt = S_HALTED;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr_sel   = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 2'd0;
        alu_src_b      = 1'b0;
        alu_op         = 2'd0;
        reg_write      = 1'b0;
        write_reg_sel  = 1'b0;
        write_data_sel = 2'd0;
        halted         = 1'b0;
        fault          = 1'b0;
        retire         = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_NOR: alu_op = 2'd1;
                    OP_LW, OP_SW: alu_src_b = 1'b1;
                    OP_BEQ: begin
                        alu_op   = 2'd2;
                        pc_write = alu_eq;
                        pc_src   = alu_eq ? 2'd1 : 2'd0;
                        retire   = 1'b1;
                    end
                    // Datapath reads regA before this write lands, so the jump uses the old value.
                    OP_JALR: begin
                        reg_write      = 1'b1;
                        write_data_sel = 2'd2;
                        pc_write       = 1'b1;
                        pc_src         = 2'd2;
                        retire         = 1'b1;
                    end
                    OP_HALT: retire = 1'b1;
                    OP_ADD:  alu_op = 2'd0;
                    default: retire = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                alu_src_b    = 1'b1;
                mem_we       = (op_q == OP_SW);
                retire       = (op_q == OP_SW) && mem_ready;
            end
            S_WB: begin
                reg_write      = 1'b1;
                write_reg_sel  = (op_q != OP_LW);
                write_data_sel = (op_q == OP_LW) ? 2'd1 : 2'd0;
                retire         = 1'b1;
            end
            S_HALTED: halted = 1'b1;
`ifdef LC2K_MEM_TIMEOUT_EN
            S_FAULT:  fault = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state_out     = state;
    assign instr_retired = retired_cnt;

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Scoreboard bench for lc2k_multicycle_ctrl: directed per-cycle vectors push expected state/strobes/count,
// a negedge monitor pops and compares. Timeout vectors run when LC2K_MEM_TIMEOUT_EN is defined.
module tb_lc2k_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, alu_eq, mem_ready;
    logic [2:0]  opcode;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write, write_reg_sel;
    logic [1:0]  write_data_sel;
    logic        halted, fault;
    logic [2:0]  state_out;
    logic [31:0] instr_retired;

    always #5 clk = ~clk;

    lc2k_multicycle_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .alu_eq(alu_eq),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .write_reg_sel(write_reg_sel),
        .write_data_sel(write_data_sel), .halted(halted), .fault(fault),
        .state_out(state_out), .instr_retired(instr_retired)
    );

    // Strobe vector bits: mem_req mem_we mem_addr_sel ir_write pc_write pc_src[1:0] alu_src_b
    //                     alu_op[1:0] reg_write write_reg_sel write_data_sel[1:0] halted fault
    localparam logic [15:0] O_NONE   = 16'h0000;
    localparam logic [15:0] O_FW     = 16'h8000;
    localparam logic [15:0] O_FR     = 16'h9800;
    localparam logic [15:0] O_NOR    = 16'h0040;
    localparam logic [15:0] O_LS     = 16'h0100;
    localparam logic [15:0] O_BEQ_T  = 16'h0A80;
    localparam logic [15:0] O_BEQ_N  = 16'h0080;
    localparam logic [15:0] O_JALR   = 16'h0C28;
    localparam logic [15:0] O_MEM_LW = 16'hA100;
    localparam logic [15:0] O_MEM_SW = 16'hE100;
    localparam logic [15:0] O_WB_ALU = 16'h0030;
    localparam logic [15:0] O_WB_LW  = 16'h0024;
    localparam logic [15:0] O_HALT   = 16'h0002;
    localparam logic [15:0] O_FAULT  = 16'h0001;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] o;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] act;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic step(input logic r, input logic s, input logic [2:0] op, input logic eq,
                        input logic rdy, input logic [2:0] est, input logic [15:0] eo,
                        input logic [31:0] ec);
        rst_n = r; start = s; opcode = op; alu_eq = eq; mem_ready = rdy;
        sb.push_back('{st: est, o: eo, cnt: ec});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            act = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_b,
                   alu_op, reg_write, write_reg_sel, write_data_sel, halted, fault};
            if (state_out !== e.st) begin
                miscompares++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state_out, e.st);
            end
            if (act !== e.o) begin
                miscompares++;
                $display("FAIL strobes @%0t: got %h expected %h", $time, act, e.o);
            end
            if (instr_retired !== e.cnt) begin
                miscompares++;
                $display("FAIL retired @%0t: got %0d expected %0d", $time, instr_retired, e.cnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 3'd0; alu_eq = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // add, nor, halt with memory always ready
        step(1, 1, 3'b000, 0, 1, S_IDLE,  O_NONE,   0);
        step(1, 0, 3'b000, 0, 1, S_FETCH, O_FR,     0);
        step(1, 0, 3'b000, 0, 1, S_DEC,   O_NONE,   0);
        step(1, 0, 3'b000, 0, 1, S_EXEC,  O_NONE,   0);
        step(1, 0, 3'b000, 0, 1, S_WB,    O_WB_ALU, 0);
        step(1, 0, 3'b001, 0, 1, S_FETCH, O_FR,     1);
        step(1, 0, 3'b001, 0, 1, S_DEC,   O_NONE,   1);
        step(1, 0, 3'b001, 0, 1, S_EXEC,  O_NOR,    1);
        step(1, 0, 3'b001, 0, 1, S_WB,    O_WB_ALU, 1);
        step(1, 0, 3'b110, 0, 1, S_FETCH, O_FR,     2);
        step(1, 0, 3'b110, 0, 1, S_DEC,   O_NONE,   2);
        step(1, 0, 3'b110, 0, 1, S_EXEC,  O_NONE,   2);
        step(1, 1, 3'b000, 0, 1, S_HALT,  O_HALT,   3);
        step(0, 1, 3'b000, 0, 1, S_HALT,  O_HALT,   3);
        // lw with 3 fetch waits and 2 memory waits
        step(1, 1, 3'b010, 0, 0, S_IDLE,  O_NONE,   0);
        step(1, 0, 3'b010, 0, 0, S_FETCH, O_FW,     0);
        step(1, 0, 3'b010, 0, 0, S_FETCH, O_FW,     0);
        step(1, 0, 3'b010, 0, 0, S_FETCH, O_FW,     0);
        step(1, 0, 3'b010, 0, 1, S_FETCH, O_FR,     0);
        step(1, 0, 3'b010, 0, 0, S_DEC,   O_NONE,   0);
        step(1, 0, 3'b010, 0, 0, S_EXEC,  O_LS,     0);
        step(1, 0, 3'b010, 0, 0, S_MEM,   O_MEM_LW, 0);
        step(1, 0, 3'b010, 0, 0, S_MEM,   O_MEM_LW, 0);
        step(1, 0, 3'b010, 0, 1, S_MEM,   O_MEM_LW, 0);
        step(1, 0, 3'b010, 0, 0, S_WB,    O_WB_LW,  0);
        // beq taken, beq not taken, jalr
        step(1, 0, 3'b100, 1, 1, S_FETCH, O_FR,     1);
        step(1, 0, 3'b100, 1, 1, S_DEC,   O_NONE,   1);
        step(1, 0, 3'b100, 1, 1, S_EXEC,  O_BEQ_T,  1);
        step(1, 0, 3'b100, 0, 1, S_FETCH, O_FR,     2);
        step(1, 0, 3'b100, 0, 1, S_DEC,   O_NONE,   2);
        step(1, 0, 3'b100, 0, 1, S_EXEC,  O_BEQ_N,  2);
        step(1, 0, 3'b101, 1, 1, S_FETCH, O_FR,     3);
        step(1, 0, 3'b101, 1, 1, S_DEC,   O_NONE,   3);
        step(1, 0, 3'b101, 1, 1, S_EXEC,  O_JALR,   3);
        // sw interrupted by reset during its memory wait
        step(1, 1, 3'b011, 0, 1, S_FETCH, O_FR,     4);
        step(1, 0, 3'b011, 0, 1, S_DEC,   O_NONE,   4);
        step(1, 0, 3'b011, 0, 0, S_EXEC,  O_LS,     4);
        step(0, 0, 3'b011, 0, 0, S_MEM,   O_MEM_SW, 4);
        step(1, 1, 3'b111, 0, 1, S_IDLE,  O_NONE,   0);
        step(1, 0, 3'b111, 0, 1, S_FETCH, O_FR,     0);
        step(1, 0, 3'b111, 0, 1, S_DEC,   O_NONE,   0);
        step(1, 0, 3'b111, 0, 0, S_EXEC,  O_NONE,   0);
`ifdef LC2K_MEM_TIMEOUT_EN
        // fetch never ready: fault after the 4th wait cycle, sticky
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     1);
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     1);
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     1);
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     1);
        step(1, 1, 3'b000, 0, 1, S_FAULT, O_FAULT,  1);
        step(0, 1, 3'b000, 0, 1, S_FAULT, O_FAULT,  1);
        // ready arrives in the limit cycle: proceeds normally
        step(1, 1, 3'b000, 0, 0, S_IDLE,  O_NONE,   0);
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     0);
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     0);
        step(1, 0, 3'b000, 0, 0, S_FETCH, O_FW,     0);
        step(1, 0, 3'b000, 0, 1, S_FETCH, O_FR,     0);
        step(1, 0, 3'b000, 0, 0, S_DEC,   O_NONE,   0);
`else
        // without the timeout the fetch waits indefinitely and never faults
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 3'b000, 0, 0, S_FETCH, O_FW, 1);
        end
        step(1, 0, 3'b000, 0, 1, S_FETCH, O_FR,     1);
        step(1, 0, 3'b000, 0, 0, S_DEC,   O_NONE,   1);
`endif
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lc2k_multicycle_ctrl.md
Name: lc2k_multicycle_ctrl

Overview:
- Moore control FSM that sequences the LC2K datapath (PC, register file, ALU, unified memory) as a multi-cycle machine instead of single-cycle ROM decode.
- Issues per-state control strobes, handles the memory ready handshake, counts retired instructions and parks on halt.
- Sits beside the CPU datapath; consumes the instruction opcode and the ALU equal flag.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 64, memory wait limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin execution from IDLE
- opcode  in  3  instruction[24:22] from the instruction register
- alu_eq  in  1  ALU equal flag (regA == regB)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write (sw)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = regA value
- alu_src_b  out  1  0 = regB, 1 = sign-extended offset
- alu_op  out  2  0 = add, 1 = nor, 2 = compare
- reg_write  out  1  register file write enable
- write_reg_sel  out  1  0 = regB field, 1 = destReg field
- write_data_sel  out  2  0 = ALU, 1 = memory data, 2 = PC
- halted  out  1  halt retired
- fault  out  1  memory timeout (0 without the optional feature)
- state_out  out  3  current state encoding
- instr_retired  out  CNT_W  retired-instruction count

Behaviour:
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALTED = 6, FAULT = 7.
- Reset:
  - rst_n low at a clock edge forces IDLE from any state, including mid-memory wait.
  - Clears instr_retired, the wait counter and op_q.
  - All outputs are 0 in IDLE, so every output reads 0 after reset.
- IDLE: go to FETCH when start = 1. start is ignored in every other state.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0; held until mem_ready = 1.
  - On the mem_ready cycle: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE: latch opcode into op_q; go to EXEC. No strobes.
- EXEC, decoded on op_q:
  - add (000): alu_op = 0, alu_src_b = 0; go to WB.
  - nor (001): alu_op = 1, alu_src_b = 0; go to WB.
  - lw (010) / sw (011): alu_op = 0, alu_src_b = 1; go to MEM.
  - beq (100): alu_op = 2, alu_src_b = 0. If alu_eq = 1: pc_write = 1, pc_src = 1. Retire; go to FETCH.
  - jalr (101): reg_write = 1, write_reg_sel = 0, write_data_sel = 2, pc_write = 1, pc_src = 2. Retire; go to FETCH. The datapath reads regA before the write, so regA == regB jumps to the old value.
  - halt (110): retire; go to HALTED.
  - noop (111): retire; go to FETCH.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, alu_src_b = 1, alu_op = 0; mem_we = 1 for sw. Held until mem_ready = 1.
  - lw goes to WB.
  - sw retires on the mem_ready cycle and goes to FETCH.
- WB:
  - reg_write = 1.
  - add/nor: write_reg_sel = 1, write_data_sel = 0.
  - lw: write_reg_sel = 0, write_data_sel = 1.
  - Retire; go to FETCH.
- Latency (no wait states): add/nor = 4 cycles; lw = 5; sw = 4; beq/jalr/noop/halt = 3. Each mem_ready = 0 cycle adds one.
- Retire: instr_retired increments by 1 on the final cycle of each instruction; wraps modulo 2^CNT_W.
- HALTED: halted = 1, all strobes 0; stay until reset.
- Handshake: mem_ready is ignored while mem_req = 0. mem_req never drops before mem_ready is sampled high.

Optional Feature:
- Macro: LC2K_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter increments on each FETCH/MEM cycle with mem_ready = 0 and clears on leaving those states.
  - When the counter equals TIMEOUT_CYCLES - 1 and mem_ready = 0, go to FAULT.
  - In FAULT: fault = 1, all strobes 0, no retire; sticky until reset.
  - If mem_ready = 1 in the limit cycle, mem_ready wins and the FSM proceeds normally.
- Undefined: no counter; the FSM waits indefinitely; fault is tied to 0; FAULT is unreachable.

Test Plan:
- Reset, then start = 1 with memory always ready; program add, nor, halt -> state sequence 1,2,3,5,1,2,3,5,1,2,3,6; halted = 1 at cycle 12; instr_retired = 3.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEM -> mem_req held high throughout; lw completes in 10 cycles; WB shows reg_write = 1, write_reg_sel = 0, write_data_sel = 1.
- beq with alu_eq = 1, then alu_eq = 0 -> pc_write = 1, pc_src = 1 only in the first EXEC; the second EXEC has pc_write = 0; both retire.
- jalr -> a single EXEC cycle with reg_write = 1, write_data_sel = 2, pc_write = 1, pc_src = 2; next state FETCH.
- rst_n low during a MEM wait of sw -> next cycle state_out = 0, mem_req = 0, instr_retired = 0; start = 1 restarts at FETCH.
- With LC2K_MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, mem_ready held 0 in FETCH -> FAULT after the 4th wait cycle, fault = 1, mem_req = 0. Repeat with mem_ready = 1 on the 4th wait cycle -> DECODE, fault = 0.
